carrd_vdispatch: RTL and testbench

// Scalar-core-side dispatcher for the CARRD vector coprocessor. Captures OP-V

---
 rtl/carrd_vdispatch.sv | 129 ++++++++++++
 tb/tb_carrd_vdispatch.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/carrd_vdispatch.sv
// OP-V instruction dispatcher: queues vector instructions with their rs1 operand,
// issues them one at a time to the coprocessor and writes scalar results back.
//
// state  | meaning
// IDLE   | nothing in flight; pops the FIFO head when one is queued
// ISSUE  | cp_valid_o held with stable instr/xreg until the coprocessor accepts
// WAIT   | accepted, waiting for the cp_done_i pulse
// WB     | one-cycle scalar register write of the latched result
module carrd_vdispatch #(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             instr_valid_i,
    input  logic [31:0]      instr_i,
    input  logic [31:0]      rs1_data_i,
    output logic             instr_ready_o,
    input  logic             flush_i,
    output logic [31:0]      cp_instr_o,
    output logic [31:0]      cp_xreg_o,
    output logic             cp_valid_o,
    input  logic             cp_accept_i,
    input  logic             cp_done_i,
    input  logic             cp_xwr_i,
    input  logic [31:0]      cp_xresult_i,
    output logic             xwb_en_o,
    output logic [4:0]       xwb_addr_o,
    output logic [31:0]      xwb_data_o,
    output logic             busy_o,
    output logic [PTR_W:0]   count_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_WB    = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [31:0]    instr_mem [DEPTH];
    logic [31:0]    rs1_mem   [DEPTH];
    logic [PTR_W:0] wr_ptr_q, rd_ptr_q;
    logic           full, empty, enq, pop, wb_latch;
    logic [31:0]    cp_instr_q, cp_xreg_q, xwb_data_q;
    logic [4:0]     xwb_addr_q;

    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    // Flush discards a same-cycle enqueue as well as everything already queued.
    assign enq = instr_valid_i && !full && (instr_i[6:0] == 7'h57) && !flush_i;

    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        wb_latch = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty && !flush_i) begin
                    pop     = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (cp_accept_i) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cp_done_i) begin
                    if (cp_xwr_i && (cp_instr_q[11:7] != 5'd0)) begin
                        wb_latch = 1'b1;
                        state_d  = S_WB;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            instr_mem[wr_ptr_q[PTR_W-1:0]] <= instr_i;
            rs1_mem[wr_ptr_q[PTR_W-1:0]]   <= rs1_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cp_instr_q <= '0;
            cp_xreg_q  <= '0;
            xwb_addr_q <= '0;
            xwb_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (enq) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (flush_i)  rd_ptr_q <= wr_ptr_q;
            else if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (pop) begin
                cp_instr_q <= instr_mem[rd_ptr_q[PTR_W-1:0]];
                cp_xreg_q  <= rs1_mem[rd_ptr_q[PTR_W-1:0]];
            end
            if (wb_latch) begin
                xwb_addr_q <= cp_instr_q[11:7];
                xwb_data_q <= cp_xresult_i;
            end
        end
    end

    assign instr_ready_o = !full;
    assign count_o       = wr_ptr_q - rd_ptr_q;
    assign cp_valid_o    = (state_q == S_ISSUE);
    assign cp_instr_o    = cp_instr_q;
    assign cp_xreg_o     = cp_xreg_q;
    assign xwb_en_o      = (state_q == S_WB);
    assign xwb_addr_o    = xwb_addr_q;
    assign xwb_data_o    = xwb_data_q;
    assign busy_o        = !empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_carrd_vdispatch.sv
// Bench for carrd_vdispatch: directed scenarios plus random traffic, checked
// every cycle against a transaction-level queue model of the dispatcher.
module tb_carrd_vdispatch;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        nrst;
    logic        instr_valid_i;
    logic [31:0] instr_i;
    logic [31:0] rs1_data_i;
    logic        instr_ready_o;
    logic        flush_i;
    logic [31:0] cp_instr_o;
    logic [31:0] cp_xreg_o;
    logic        cp_valid_o;
    logic        cp_accept_i;
    logic        cp_done_i;
    logic        cp_xwr_i;
    logic [31:0] cp_xresult_i;
    logic        xwb_en_o;
    logic [4:0]  xwb_addr_o;
    logic [31:0] xwb_data_o;
    logic        busy_o;
    logic [2:0]  count_o;

    carrd_vdispatch #(.DEPTH(DEPTH)) dut (
        .clk(clk), .nrst(nrst),
        .instr_valid_i(instr_valid_i), .instr_i(instr_i), .rs1_data_i(rs1_data_i),
        .instr_ready_o(instr_ready_o), .flush_i(flush_i),
        .cp_instr_o(cp_instr_o), .cp_xreg_o(cp_xreg_o), .cp_valid_o(cp_valid_o),
        .cp_accept_i(cp_accept_i), .cp_done_i(cp_done_i), .cp_xwr_i(cp_xwr_i),
        .cp_xresult_i(cp_xresult_i), .xwb_en_o(xwb_en_o), .xwb_addr_o(xwb_addr_o),
        .xwb_data_o(xwb_data_o), .busy_o(busy_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: queued entries, the op currently owned by the dispatcher
    // and where it is in its life (awaiting accept, awaiting done, writing back).
    logic [63:0] mq[$];
    logic [63:0] m_entry;
    logic        m_have_op, m_accepted, m_wb, m_enq_ok;
    logic [31:0] m_instr, m_xreg, m_wb_data;
    logic [4:0]  m_wb_addr;

    logic [31:0] issue_log[$];
    logic [31:0] fill_ops[5];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task model_update();
        if (nrst) begin
            mq.delete();
            m_have_op  = 1'b0;
            m_accepted = 1'b0;
            m_wb       = 1'b0;
            m_instr    = '0;
            m_xreg     = '0;
            m_wb_addr  = '0;
            m_wb_data  = '0;
        end else begin
            m_enq_ok = instr_valid_i && (mq.size() < DEPTH) &&
                       (instr_i[6:0] == 7'h57) && !flush_i;
            if (!m_have_op) begin
                if (mq.size() > 0 && !flush_i) begin
                    m_entry    = mq.pop_front();
                    m_instr    = m_entry[63:32];
                    m_xreg     = m_entry[31:0];
                    m_have_op  = 1'b1;
                    m_accepted = 1'b0;
                end
            end else if (m_wb) begin
                m_wb      = 1'b0;
                m_have_op = 1'b0;
            end else if (!m_accepted) begin
                if (cp_accept_i) m_accepted = 1'b1;
            end else if (cp_done_i) begin
                if (cp_xwr_i && m_instr[11:7] != 5'd0) begin
                    m_wb      = 1'b1;
                    m_wb_addr = m_instr[11:7];
                    m_wb_data = cp_xresult_i;
                end else begin
                    m_have_op = 1'b0;
                end
            end
            if (flush_i) mq.delete();
            if (m_enq_ok) mq.push_back({instr_i, rs1_data_i});
        end
    endtask

    task model_compare();
        chk("ready", instr_ready_o, mq.size() < DEPTH);
        chk("count", count_o, mq.size());
        chk("busy", busy_o, (mq.size() > 0) || m_have_op);
        chk("cp_valid", cp_valid_o, m_have_op && !m_accepted);
        if (m_have_op && !m_accepted) begin
            chk("cp_instr", cp_instr_o, m_instr);
            chk("cp_xreg", cp_xreg_o, m_xreg);
        end
        chk("xwb_en", xwb_en_o, m_wb);
        if (m_wb) begin
            chk("xwb_addr", xwb_addr_o, m_wb_addr);
            chk("xwb_data", xwb_data_o, m_wb_data);
        end
    endtask

    task step();
        @(posedge clk);
        model_update();
        #1;
        model_compare();
    endtask

    task quiet();
        instr_valid_i = 1'b0;
        flush_i       = 1'b0;
        cp_accept_i   = 1'b0;
        cp_done_i     = 1'b0;
        cp_xwr_i      = 1'b0;
    endtask

    task push_op(input logic [31:0] ins, input logic [31:0] rs1);
        instr_valid_i = 1'b1;
        instr_i       = ins;
        rs1_data_i    = rs1;
        step();
        instr_valid_i = 1'b0;
    endtask

    // Brings a single queued op from IDLE through ISSUE into WAIT.
    task issue_and_accept();
        step();
        step();
        cp_accept_i = 1'b1;
        step();
        cp_accept_i = 1'b0;
    endtask

    initial begin
        quiet();
        instr_i      = '0;
        rs1_data_i   = '0;
        cp_xresult_i = '0;
        nrst         = 1'b1;
        step();
        step();
        nrst = 1'b0;
        chk("rst_ready", instr_ready_o, 1);
        chk("rst_valid", cp_valid_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_xwb_en", xwb_en_o, 0);
        chk("rst_cp_instr", cp_instr_o, 0);

        // Basic issue latency
        push_op(32'h0220_8057, 32'hDEAD_BEEF);
        chk("lat_n1_valid", cp_valid_o, 0);
        step();
        chk("lat_n2_valid", cp_valid_o, 1);
        chk("lat_instr", cp_instr_o, 32'h0220_8057);
        chk("lat_xreg", cp_xreg_o, 32'hDEAD_BEEF);
        cp_accept_i = 1'b1;
        step();
        cp_accept_i = 1'b0;
        chk("acc_valid", cp_valid_o, 0);
        cp_done_i = 1'b1;
        step();
        cp_done_i = 1'b0;
        chk("done_busy", busy_o, 0);

        // Fill the FIFO while the head op waits for accept
        for (int i = 0; i < 5; i++) begin
            fill_ops[i] = 32'h0000_0057 | (32'(i + 1) << 15) | (32'(i + 1) << 7);
            push_op(fill_ops[i], 32'(i) * 32'h1111_0000);
        end
        chk("full_ready", instr_ready_o, 0);
        chk("full_count", count_o, 4);
        push_op(32'h0BAD_0057, 32'h0);
        cp_accept_i = 1'b1;
        cp_done_i   = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (cp_valid_o) issue_log.push_back(cp_instr_o);
            step();
        end
        quiet();
        chk("order_len", issue_log.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < issue_log.size()) chk("order", issue_log[i], fill_ops[i]);
        chk("drain_busy", busy_o, 0);

        // Scalar writeback to x5
        push_op(32'h4200_22D7, 32'h0);
        issue_and_accept();
        cp_done_i    = 1'b1;
        cp_xwr_i     = 1'b1;
        cp_xresult_i = 32'h0000_00AB;
        step();
        quiet();
        chk("wb_en", xwb_en_o, 1);
        chk("wb_addr", xwb_addr_o, 5);
        chk("wb_data", xwb_data_o, 32'h0000_00AB);
        step();
        chk("wb_one_cycle", xwb_en_o, 0);

        // Writeback to x0 is suppressed
        push_op(32'h4200_2057, 32'h0);
        issue_and_accept();
        cp_done_i    = 1'b1;
        cp_xwr_i     = 1'b1;
        cp_xresult_i = 32'h0000_0077;
        step();
        quiet();
        chk("x0_wb_en", xwb_en_o, 0);
        chk("x0_busy", busy_o, 0);
        step();
        chk("x0_wb_en2", xwb_en_o, 0);

        // Non-OP-V words are ignored
        push_op(32'h0000_0013, 32'h1234_5678);
        chk("addi_count", count_o, 0);
        chk("addi_ready", instr_ready_o, 1);
        step();
        chk("addi_valid", cp_valid_o, 0);

        // Flush with an op in WAIT, then reset with an op in WAIT
        push_op(32'h0000_01D7, 32'hA5A5_0001);
        issue_and_accept();
        push_op(32'h0000_1057, 32'h2);
        push_op(32'h0000_2057, 32'h3);
        push_op(32'h0000_3057, 32'h4);
        chk("pre_flush_count", count_o, 3);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("flush_count", count_o, 0);
        chk("flush_busy", busy_o, 1);
        cp_done_i    = 1'b1;
        cp_xwr_i     = 1'b1;
        cp_xresult_i = 32'h0000_0055;
        step();
        quiet();
        chk("flush_wb_en", xwb_en_o, 1);
        chk("flush_wb_addr", xwb_addr_o, 3);
        step();
        chk("flush_idle_busy", busy_o, 0);

        push_op(32'h0000_0257, 32'h9);
        issue_and_accept();
        push_op(32'h0000_4057, 32'h7);
        nrst = 1'b1;
        step();
        nrst = 1'b0;
        chk("wrst_ready", instr_ready_o, 1);
        chk("wrst_count", count_o, 0);
        chk("wrst_busy", busy_o, 0);
        chk("wrst_cp_instr", cp_instr_o, 0);
        chk("wrst_xwb_data", xwb_data_o, 0);
        cp_done_i    = 1'b1;
        cp_xwr_i     = 1'b1;
        cp_xresult_i = 32'hFFFF_0000;
        step();
        quiet();
        step();
        chk("wrst_late_done", xwb_en_o, 0);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            instr_valid_i = 1'($urandom_range(1));
            instr_i       = $urandom;
            if ($urandom_range(9) < 7) instr_i[6:0] = 7'h57;
            rs1_data_i    = $urandom;
            flush_i       = ($urandom_range(39) == 0);
            cp_accept_i   = 1'($urandom_range(1));
            cp_done_i     = ($urandom_range(9) < 3);
            cp_xwr_i      = 1'($urandom_range(1));
            cp_xresult_i  = $urandom;
            step();
        end
        quiet();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
